wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the modified MIPS pipeline, directly downstream of the MEM/WB pipeline register. Selects the write-back value from the four MEM/WB sources and drives the integer and floating-point register-file write ports. A double-word float write (iFloat=1, iDW=1) is sequenced over two cycles on the single FP write port, stalling the front of the pipeline for one cycle.

## Interface
- No parameters; widths are fixed at 32-bit data and 5-bit register addresses.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- iWrite  in  1  instruction writes a register.
- iFloat  in  1  destination is the FP register file.
- iWBsrc  in  2  source select: 0 ALU, 1 memory, 2 PC+4, 3 immediate.
- iDW  in  1  double-word FP write.
- iALUout1, iALUout2  in  32  ALU low and high words.
- iMemOut1, iMemOut2  in  32  memory low and high words.
- iPcp4, iIm  in  32  link address and immediate.
- iDstReg  in  5  destination register.
- oRegWrite  out  1, oRegAddr  out  5, oRegData  out  32  integer register-file write port.
- oFpWrite  out  1, oFpAddr  out  5, oFpData  out  32  FP register-file write port.
- oStall  out  1  combinational; freezes IF..EX/MEM and forces a bubble into MEM/WB.
- oErr  out  1  sticky error flag (only with WB_ERRCHK_EN).

## Operation
- FSM states: IDLE, HIGH.
- Source value: WBsrc 0 gives iALUout1, 1 gives iMemOut1, 2 gives iPcp4, 3 gives iIm.
- IDLE, iWrite=1, iFloat=0: oRegWrite=1 unless iDstReg=0, which is suppressed and leaves $0 hardwired zero. oRegAddr=iDstReg, oRegData=value.
- IDLE, iWrite=1, iFloat=1, iDW=0: oFpWrite=1, oFpAddr=iDstReg, oFpData=value.
- IDLE, iWrite=1, iFloat=1, iDW=1:
  - oFpWrite=1 to the even register {iDstReg[4:1],0} with the low word.
  - The high word is captured: iALUout2 if WBsrc=0, iMemOut2 if WBsrc=1, and 0 for WBsrc 2/3.
  - The odd address is captured.
  - oStall=1 this cycle; next state is HIGH.
- HIGH: oFpWrite=1 to {dst[4:1],1} with the captured high word. All inputs are ignored. oStall=0. Next state is IDLE.
- iDW is ignored when iFloat=0.
- iWrite=0: no write ports are asserted.
- Integer and FP write ports are never both active in the same cycle.

## Timing
- Write ports are combinational from inputs (IDLE) or held state (HIGH). The register file commits on the same rising edge.
- Single-word latency is 0 cycles after MEM/WB. A double-word write occupies 2 cycles.
- oStall is high exactly one cycle per double-word instruction: the IDLE cycle where the DW instruction is present.
  - In that cycle the upstream hazard unit must load a bubble (iWrite=0) into MEM/WB.
- Reset values:
  - State = IDLE; captured high word = 0; captured address = 0; oErr = 0.
  - While rst=1: oRegWrite, oFpWrite and oStall are forced to 0, and address/data outputs are 0.
- Reset during HIGH: the pending high write is dropped and the FSM returns to IDLE.
- Back-to-back DW instructions are separated by the enforced bubble. A DW arriving in the cycle after HIGH starts normally.

## Configuration
- WB_ERRCHK_EN defined: oErr is present and sets, holding until rst, on either condition:
  - iWrite=1 received in HIGH (bubble protocol violation; the instruction is still ignored).
  - DW with odd iDstReg (the write still uses the pair {dst[4:1],0/1}).
- WB_ERRCHK_EN undefined: oErr is tied to 0 and the checker logic is absent. Write behaviour is identical in both builds.

## Structure
- Shared package mips_pkg holds:
  - WBsrc encodings WBSRC_ALU=2'd0, WBSRC_MEM=2'd1, WBSRC_PC4=2'd2, WBSRC_IMM=2'd3.
  - The FSM state typedef wb_state_t.
  - Widths XLEN=32 and RADDR=5.
- One sub-module, wb_mux: combinational 4:1 source select plus high-word select. The FSM, capture registers and port steering live in wb_stage.

## Test plan
- Integer ALU write: iWrite=1, iFloat=0, WBsrc=0, iALUout1=32'h1234_5678, dst=5 -> oRegWrite=1, oRegAddr=5, oRegData=32'h1234_5678, oFpWrite=0, oStall=0.
- $0 suppression: iWrite=1, iFloat=0, dst=0, WBsrc=2, iPcp4=32'h40 -> oRegWrite=0.
- Double-word load: iFloat=1, iDW=1, WBsrc=1, iMemOut1=32'hAAAA_0000, iMemOut2=32'hBBBB_1111, dst=6, then bubble:
  - Cycle 0: oFpWrite to 6 with AAAA_0000, oStall=1.
  - Cycle 1: oFpWrite to 7 with BBBB_1111, oStall=0.
- Reset mid-operation: rst=1 during HIGH of a DW to dst=2 -> no write to reg 3, all write enables 0; after rst drops, a single FP write to dst=4 proceeds normally.
- Error check (WB_ERRCHK_EN): DW with dst=9 writes regs 8 and 9 and sets oErr=1. In a separate run, iWrite=1 during HIGH is ignored and sets oErr=1, which stays set until rst.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared widths, write-back source encodings and WB FSM state
//                type for the modified MIPS pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    localparam logic [1:0] WBSRC_ALU = 2'd0;
    localparam logic [1:0] WBSRC_MEM = 2'd1;
    localparam logic [1:0] WBSRC_PC4 = 2'd2;
    localparam logic [1:0] WBSRC_IMM = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HIGH = 1'b1
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_mux.sv
// ============================================================================
//  Module      : wb_mux
//  Description : Write-back source select: low word from one of four sources,
//                high word from the ALU/memory pair (zero for PC+4/immediate).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mux
    import mips_pkg::*;
(
    input  logic [1:0]      wbSrc,
    input  logic [XLEN-1:0] aluOut1,
    input  logic [XLEN-1:0] aluOut2,
    input  logic [XLEN-1:0] memOut1,
    input  logic [XLEN-1:0] memOut2,
    input  logic [XLEN-1:0] pcp4,
    input  logic [XLEN-1:0] im,
    output logic [XLEN-1:0] lowWord,
    output logic [XLEN-1:0] highWord
);

    always_comb begin
        lowWord  = '0;
        highWord = '0;
        case (wbSrc)
            WBSRC_ALU: begin
                lowWord  = aluOut1;
                highWord = aluOut2;
            end
            WBSRC_MEM: begin
                lowWord  = memOut1;
                highWord = memOut2;
            end
            WBSRC_PC4: lowWord = pcp4;
            WBSRC_IMM: lowWord = im;
            default:   lowWord = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
//  Module      : wb_stage
//  Description : MIPS write-back stage; drives integer and FP register-file
//                write ports and sequences double-word FP writes over two
//                cycles. Define WB_ERRCHK_EN to enable the sticky oErr checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             iWrite,
    input  logic             iFloat,
    input  logic [1:0]       iWBsrc,
    input  logic             iDW,
    input  logic [XLEN-1:0]  iALUout1,
    input  logic [XLEN-1:0]  iALUout2,
    input  logic [XLEN-1:0]  iMemOut1,
    input  logic [XLEN-1:0]  iMemOut2,
    input  logic [XLEN-1:0]  iPcp4,
    input  logic [XLEN-1:0]  iIm,
    input  logic [RADDR-1:0] iDstReg,
    output logic             oRegWrite,
    output logic [RADDR-1:0] oRegAddr,
    output logic [XLEN-1:0]  oRegData,
    output logic             oFpWrite,
    output logic [RADDR-1:0] oFpAddr,
    output logic [XLEN-1:0]  oFpData,
    output logic             oStall,
    output logic             oErr
);

    wb_state_t        r_state;
    wb_state_t        w_nextState;
    logic [XLEN-1:0]  r_hiWord;
    logic [RADDR-1:0] r_hiAddr;
    logic [XLEN-1:0]  w_lowWord;
    logic [XLEN-1:0]  w_highWord;
    logic             w_capture;

    wb_mux u_mux (
        .wbSrc    (iWBsrc),
        .aluOut1  (iALUout1),
        .aluOut2  (iALUout2),
        .memOut1  (iMemOut1),
        .memOut2  (iMemOut2),
        .pcp4     (iPcp4),
        .im       (iIm),
        .lowWord  (w_lowWord),
        .highWord (w_highWord)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_hiWord <= '0;
            r_hiAddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_capture) begin
                r_hiWord <= w_highWord;
                r_hiAddr <= {iDstReg[RADDR-1:1], 1'b1};
            end
        end
    end

    // Outputs stay quiet while rst is high, whatever the state register holds.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        oRegWrite   = 1'b0;
        oRegAddr    = '0;
        oRegData    = '0;
        oFpWrite    = 1'b0;
        oFpAddr     = '0;
        oFpData     = '0;
        oStall      = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (iWrite && !iFloat) begin
                        oRegWrite = (iDstReg != '0);
                        oRegAddr  = iDstReg;
                        oRegData  = w_lowWord;
                    end else if (iWrite && iDW) begin
                        oFpWrite    = 1'b1;
                        oFpAddr     = {iDstReg[RADDR-1:1], 1'b0};
                        oFpData     = w_lowWord;
                        oStall      = 1'b1;
                        w_capture   = 1'b1;
                        w_nextState = HIGH;
                    end else if (iWrite) begin
                        oFpWrite = 1'b1;
                        oFpAddr  = iDstReg;
                        oFpData  = w_lowWord;
                    end
                end
                HIGH: begin
                    oFpWrite    = 1'b1;
                    oFpAddr     = r_hiAddr;
                    oFpData     = r_hiWord;
                    w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

`ifdef WB_ERRCHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == HIGH && iWrite) ||
                     (r_state == IDLE && iWrite && iFloat && iDW && iDstReg[0])) begin
            r_err <= 1'b1;
        end
    end

    assign oErr = r_err;
`else
    assign oErr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage: vector table, directed
//                double-word/reset/error sequences and randomized model check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

`ifdef WB_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        wr;
        logic        fl;
        logic        dw;
        logic [1:0]  src;
        logic [4:0]  dst;
        logic [31:0] alu1;
        logic [31:0] alu2;
        logic [31:0] mem1;
        logic [31:0] mem2;
        logic [31:0] pcp4;
        logic [31:0] im;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic        regWr;
        logic [4:0]  regAddr;
        logic [31:0] regData;
        logic        fpWr;
        logic [4:0]  fpAddr;
        logic [31:0] fpData;
        logic        stall;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, iWrite, iFloat, iDW;
    logic [1:0]  iWBsrc;
    logic [31:0] iALUout1, iALUout2, iMemOut1, iMemOut2, iPcp4, iIm;
    logic [4:0]  iDstReg;
    logic        oRegWrite, oFpWrite, oStall, oErr;
    logic [4:0]  oRegAddr, oFpAddr;
    logic [31:0] oRegData, oFpData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .iWrite(iWrite), .iFloat(iFloat), .iWBsrc(iWBsrc),
        .iDW(iDW), .iALUout1(iALUout1), .iALUout2(iALUout2), .iMemOut1(iMemOut1),
        .iMemOut2(iMemOut2), .iPcp4(iPcp4), .iIm(iIm), .iDstReg(iDstReg),
        .oRegWrite(oRegWrite), .oRegAddr(oRegAddr), .oRegData(oRegData),
        .oFpWrite(oFpWrite), .oFpAddr(oFpAddr), .oFpData(oFpData),
        .oStall(oStall), .oErr(oErr)
    );

    function automatic in_t mk(logic r, logic w, logic f, logic d, logic [1:0] s, logic [4:0] dst);
        in_t v;
        v.rst = r; v.wr = w; v.fl = f; v.dw = d; v.src = s; v.dst = dst;
        v.alu1 = 32'h1234_5678; v.alu2 = 32'h2222_2222;
        v.mem1 = 32'h3333_3333; v.mem2 = 32'h4444_4444;
        v.pcp4 = 32'h0000_0040; v.im   = 32'h5555_5555;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic drive(input in_t v);
        @(negedge clk);
        rst = v.rst; iWrite = v.wr; iFloat = v.fl; iDW = v.dw; iWBsrc = v.src;
        iDstReg = v.dst; iALUout1 = v.alu1; iALUout2 = v.alu2; iMemOut1 = v.mem1;
        iMemOut2 = v.mem2; iPcp4 = v.pcp4; iIm = v.im;
        #2;
    endtask

    task automatic chkPorts(input string nm, input logic rw, input logic [4:0] ra,
                            input logic [31:0] rd, input logic fw, input logic [4:0] fa,
                            input logic [31:0] fd, input logic st);
        chk({nm, ".regWr"}, {31'd0, oRegWrite}, {31'd0, rw});
        chk({nm, ".fpWr"},  {31'd0, oFpWrite},  {31'd0, fw});
        chk({nm, ".stall"}, {31'd0, oStall},    {31'd0, st});
        if (rw) begin
            chk({nm, ".regAddr"}, {27'd0, oRegAddr}, {27'd0, ra});
            chk({nm, ".regData"}, oRegData, rd);
        end
        if (fw) begin
            chk({nm, ".fpAddr"}, {27'd0, oFpAddr}, {27'd0, fa});
            chk({nm, ".fpData"}, oFpData, fd);
        end
    endtask

    vec_t tbl[8];
    in_t  v;
    wr_t  pend[$];
    logic modelErr;

    initial begin
        // Single-cycle cases, all from IDLE.
        tbl[0] = '{mk(0,1,0,0,2'd0,5'd5),  1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0,  32'h0, 1'b0};
        tbl[1] = '{mk(0,1,0,0,2'd2,5'd0),  1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b0};
        tbl[2] = '{mk(0,1,0,0,2'd1,5'd31), 1'b1, 5'd31, 32'h3333_3333, 1'b0, 5'd0,  32'h0, 1'b0};
        tbl[3] = '{mk(0,1,0,0,2'd3,5'd1),  1'b1, 5'd1,  32'h5555_5555, 1'b0, 5'd0,  32'h0, 1'b0};
        tbl[4] = '{mk(0,1,1,0,2'd0,5'd10), 1'b0, 5'd0,  32'h0, 1'b1, 5'd10, 32'h1234_5678, 1'b0};
        tbl[5] = '{mk(0,1,1,0,2'd2,5'd0),  1'b0, 5'd0,  32'h0, 1'b1, 5'd0,  32'h0000_0040, 1'b0};
        tbl[6] = '{mk(0,0,1,1,2'd1,5'd6),  1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0, 1'b0};
        tbl[7] = '{mk(0,1,0,1,2'd1,5'd3),  1'b1, 5'd3,  32'h3333_3333, 1'b0, 5'd0,  32'h0, 1'b0};

        drive(mk(1,1,1,1,2'd0,5'd7));
        drive(mk(1,1,0,0,2'd0,5'd7));
        chkPorts("reset", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("reset.regAddr", {27'd0, oRegAddr}, 32'd0);
        chk("reset.fpData", oFpData, 32'd0);
        chk("reset.err", {31'd0, oErr}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].in);
            chkPorts($sformatf("vec%0d", i), tbl[i].regWr, tbl[i].regAddr, tbl[i].regData,
                     tbl[i].fpWr, tbl[i].fpAddr, tbl[i].fpData, tbl[i].stall);
        end

        // Double-word load then bubble.
        v = mk(0,1,1,1,2'd1,5'd6); v.mem1 = 32'hAAAA_0000; v.mem2 = 32'hBBBB_1111;
        drive(v);
        chkPorts("dwLoad.c0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hAAAA_0000, 1'b1);
        drive(mk(0,0,0,0,2'd0,5'd0));
        chkPorts("dwLoad.c1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hBBBB_1111, 1'b0);
        drive(mk(0,0,0,0,2'd0,5'd0));
        chkPorts("dwLoad.c2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // PC+4 source: high word is zero; a second DW follows directly after HIGH.
        drive(mk(0,1,1,1,2'd2,5'd12));
        chkPorts("dwPc.c0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h40, 1'b1);
        drive(mk(0,0,0,0,2'd0,5'd0));
        chkPorts("dwPc.c1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h0, 1'b0);
        drive(mk(0,1,1,1,2'd0,5'd20));
        chkPorts("dwB2b.c0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h1234_5678, 1'b1);
        drive(mk(0,0,0,0,2'd0,5'd0));
        chkPorts("dwB2b.c1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'h2222_2222, 1'b0);

        // Reset during HIGH drops the pending write.
        drive(mk(0,1,1,1,2'd0,5'd2));
        chkPorts("rstMid.c0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h1234_5678, 1'b1);
        drive(mk(1,0,0,0,2'd0,5'd0));
        chkPorts("rstMid.c1", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rstMid.fpAddr", {27'd0, oFpAddr}, 32'd0);
        drive(mk(0,1,1,0,2'd3,5'd4));
        chkPorts("rstMid.c2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h5555_5555, 1'b0);
        drive(mk(0,0,0,0,2'd0,5'd0));
        chkPorts("rstMid.c3", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Odd destination on a DW: pair 8/9, error flag when the checker is built.
        drive(mk(0,1,1,1,2'd1,5'd9));
        chkPorts("dwOdd.c0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h3333_3333, 1'b1);
        drive(mk(0,0,0,0,2'd0,5'd0));
        chkPorts("dwOdd.c1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h4444_4444, 1'b0);
        chk("dwOdd.err", {31'd0, oErr}, {31'd0, ERRCHK});
        drive(mk(1,0,0,0,2'd0,5'd0));
        drive(mk(0,0,0,0,2'd0,5'd0));
        chk("dwOdd.errClr", {31'd0, oErr}, 32'd0);

        // Write arriving in HIGH is ignored and flags a protocol error.
        drive(mk(0,1,1,1,2'd0,5'd4));
        drive(mk(0,1,0,0,2'd1,5'd11));
        chkPorts("hiWr.c1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h2222_2222, 1'b0);
        chk("hiWr.errLate", {31'd0, oErr}, 32'd0);
        drive(mk(0,0,0,0,2'd0,5'd0));
        chk("hiWr.err", {31'd0, oErr}, {31'd0, ERRCHK});
        drive(mk(0,1,0,0,2'd0,5'd3));
        chk("hiWr.errHold", {31'd0, oErr}, {31'd0, ERRCHK});
        drive(mk(1,0,0,0,2'd0,5'd0));
        drive(mk(0,0,0,0,2'd0,5'd0));
        chk("hiWr.errClr", {31'd0, oErr}, 32'd0);

        // Randomized run against a pending-write queue model.
        pend.delete();
        modelErr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] srcs[4];
            logic [31:0] hi;
            logic        eRw, eFw, eSt, eErrNext;
            logic [4:0]  eRa, eFa;
            logic [31:0] eRd, eFd;
            wr_t         p;
            v.rst  = ($urandom_range(0, 39) == 0);
            v.wr   = ($urandom_range(0, 3) != 0);
            v.fl   = $urandom_range(0, 1);
            v.dw   = $urandom_range(0, 1);
            v.src  = 2'($urandom_range(0, 3));
            v.dst  = 5'($urandom_range(0, 31));
            v.alu1 = $urandom; v.alu2 = $urandom; v.mem1 = $urandom;
            v.mem2 = $urandom; v.pcp4 = $urandom; v.im = $urandom;
            drive(v);
            srcs[0] = v.alu1; srcs[1] = v.mem1; srcs[2] = v.pcp4; srcs[3] = v.im;
            hi = (v.src == 2'd0) ? v.alu2 : (v.src == 2'd1) ? v.mem2 : 32'd0;
            eRw = 0; eFw = 0; eSt = 0; eRa = 0; eFa = 0; eRd = 0; eFd = 0;
            eErrNext = modelErr;
            if (v.rst) begin
                pend.delete();
                eErrNext = 1'b0;
            end else if (pend.size() != 0) begin
                p = pend.pop_front();
                eFw = 1; eFa = p.addr; eFd = p.data;
                if (v.wr) eErrNext = ERRCHK;
            end else if (v.wr && !v.fl) begin
                eRw = (v.dst != 0); eRa = v.dst; eRd = srcs[v.src];
            end else if (v.wr && v.dw) begin
                eFw = 1; eFa = v.dst & 5'h1E; eFd = srcs[v.src]; eSt = 1;
                pend.push_back('{v.dst | 5'h01, hi});
                if (v.dst[0]) eErrNext = ERRCHK;
            end else if (v.wr) begin
                eFw = 1; eFa = v.dst; eFd = srcs[v.src];
            end
            chkPorts($sformatf("rnd%0d", n), eRw, eRa, eRd, eFw, eFa, eFd, eSt);
            chk($sformatf("rnd%0d.err", n), {31'd0, oErr}, {31'd0, modelErr & ERRCHK});
            modelErr = eErrNext;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
